// File: rtl/oci_dct_packer.sv
// Packs 2-bit branch codes into frames of up to MAX_COUNT codes for the OCI trace sink.
// Frames are emitted when full, on flush, or when tracing stops; one held output frame.
module oci_dct_packer #(
   parameter int MAX_COUNT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        trc_on,
   input  logic        br_valid,
   input  logic [1:0]  br_code,
   input  logic        flush_req,
   input  logic        out_ready,
   input  logic        overflow_clr,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        dct_valid,
   output logic        dct_overflow
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_COUNT);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN} state_t;

   state_t      state, state_nxt;
   logic [29:0] acc, acc_nxt, app_acc, ld_buf;
   logic [3:0]  acc_cnt, cnt_nxt, app_cnt, ld_cnt;
   logic        pend, pend_nxt;
   logic        ld, drop, free, take, full, flush_any;

   always_comb begin
      free      = !dct_valid || out_ready;
      take      = (state == S_RUN) && trc_on && br_valid;
      full      = (acc_cnt == MAX_CNT);
      flush_any = flush_req || pend;
      app_acc   = take ? {acc[27:0], br_code} : acc;
      app_cnt   = take ? acc_cnt + 4'd1 : acc_cnt;
      acc_nxt   = acc;
      cnt_nxt   = acc_cnt;
      pend_nxt  = pend;
      ld        = 1'b0;
      ld_buf    = acc;
      ld_cnt    = acc_cnt;
      drop      = 1'b0;
      state_nxt = state;
      case (state)
         S_OFF: begin
            pend_nxt = 1'b0;
            if (trc_on) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (full) begin
               // A full accumulator always moves out before a new code can enter it.
               if (free) begin
                  ld       = 1'b1;
                  pend_nxt = 1'b0;
                  acc_nxt  = take ? {28'd0, br_code} : 30'd0;
                  cnt_nxt  = take ? 4'd1 : 4'd0;
               end else begin
                  drop = take;
                  if (flush_req) pend_nxt = 1'b1;
               end
            end else if (free && ((app_cnt == MAX_CNT) || (flush_any && (app_cnt != 4'd0)))) begin
               ld       = 1'b1;
               ld_buf   = app_acc;
               ld_cnt   = app_cnt;
               acc_nxt  = 30'd0;
               cnt_nxt  = 4'd0;
               pend_nxt = 1'b0;
            end else begin
               acc_nxt = app_acc;
               cnt_nxt = app_cnt;
               if (flush_any) pend_nxt = !free;
            end
            if (!trc_on) state_nxt = (acc_cnt != 4'd0) ? S_DRAIN : S_OFF;
         end
         S_DRAIN: begin
            if (acc_cnt == 4'd0) begin
               pend_nxt  = 1'b0;
               state_nxt = S_OFF;
            end else if (free) begin
               ld        = 1'b1;
               acc_nxt   = 30'd0;
               cnt_nxt   = 4'd0;
               pend_nxt  = 1'b0;
               state_nxt = S_OFF;
            end
         end
         default: state_nxt = S_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_OFF;
         acc          <= 30'd0;
         acc_cnt      <= 4'd0;
         pend         <= 1'b0;
         dct_buffer   <= 30'd0;
         dct_count    <= 4'd0;
         dct_valid    <= 1'b0;
         dct_overflow <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         acc_cnt <= cnt_nxt;
         pend    <= pend_nxt;
         if (ld) begin
            dct_buffer <= ld_buf;
            dct_count  <= ld_cnt;
            dct_valid  <= 1'b1;
         end else if (out_ready) begin
            dct_valid <= 1'b0;
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)              dct_overflow <= 1'b1;
         else if (overflow_clr) dct_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_oci_dct_packer.sv
// Bench for oci_dct_packer: directed scenarios plus randomized traffic against a
// queue-based reference model of the packing rules.
module tb_oci_dct_packer;

   localparam int MAXC = 15;

   logic        clk = 0;
   logic        reset_n = 1;
   logic        trc_on = 0, br_valid = 0, flush_req = 0, out_ready = 0, overflow_clr = 0;
   logic [1:0]  br_code = 0;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        dct_valid, dct_overflow;

   int checks = 0;
   int errors = 0;

   oci_dct_packer #(.MAX_COUNT(MAXC)) dut (
      .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .br_valid(br_valid),
      .br_code(br_code), .flush_req(flush_req), .out_ready(out_ready),
      .overflow_clr(overflow_clr), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .dct_overflow(dct_overflow)
   );

   always #5 clk = ~clk;

   // Reference model: accumulated codes and held frame kept as lists of codes.
   int m_state = 0;   // 0 off, 1 run, 2 drain
   int m_q[$];
   int m_out[$];
   bit m_valid = 0, m_pend = 0, m_ovf = 0;

   function automatic logic [29:0] pack_q(input int qq[$]);
      logic [29:0] b = '0;
      foreach (qq[i]) b = (b << 2) | 30'(qq[i]);
      return b;
   endfunction

   task automatic m_reset();
      m_q.delete(); m_out.delete();
      m_state = 0; m_valid = 0; m_pend = 0; m_ovf = 0;
   endtask

   task automatic m_emit();
      m_out = m_q; m_q.delete(); m_valid = 1; m_pend = 0;
   endtask

   task automatic model_step();
      int  old_n = m_q.size();
      int  old_state = m_state;
      bit  free = !m_valid || out_ready;
      bit  take = (m_state == 1) && trc_on && br_valid;
      bit  fl   = flush_req || m_pend;
      bit  drop = 0;
      if (!reset_n) return;
      if (m_valid && out_ready) m_valid = 0;
      if (old_state == 0) m_pend = 0;
      else if (old_state == 1) begin
         if (old_n == MAXC) begin
            if (free) begin
               m_emit();
               if (take) m_q.push_back(int'(br_code));
            end else begin
               drop = take;
               if (flush_req) m_pend = 1;
            end
         end else begin
            if (take) m_q.push_back(int'(br_code));
            if (free && (m_q.size() == MAXC || (fl && m_q.size() > 0))) m_emit();
            else if (fl) m_pend = !free;
         end
      end else begin
         if (old_n == 0) m_pend = 0;
         else if (free) m_emit();
      end
      if (drop) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      if (old_state == 0 && trc_on) m_state = 1;
      else if (old_state == 1 && !trc_on) m_state = (old_n > 0) ? 2 : 0;
      else if (old_state == 2 && (old_n == 0 || free)) m_state = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      br_valid = 0; flush_req = 0; overflow_clr = 0;
   endtask

   task automatic test_reset();
      reset_n = 1;
      #1 reset_n = 0;
      m_reset();
      #1;
      checks++;
      if ({dct_valid, dct_count, dct_buffer, dct_overflow} !== 36'd0)
         $display("FAIL reset_state got v=%0b c=%0d b=%h o=%0b want all 0",
                  dct_valid, dct_count, dct_buffer, dct_overflow);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   task automatic test_full_frame();
      trc_on = 1; out_ready = 1;
      tick();
      for (int i = 0; i < MAXC; i++) begin
         br_valid = 1; br_code = 2'b01;
         tick();
         if (i == MAXC - 2) begin
            checks++;
            if (dct_valid !== 1'b0) begin
               errors++;
               $display("FAIL full_early got v=%0b want 0", dct_valid);
            end
         end
      end
      checks++;
      if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h15555555) begin
         errors++;
         $display("FAIL full_frame got v=%0b c=%0d b=%h want 1/15/15555555",
                  dct_valid, dct_count, dct_buffer);
      end
      idle_inputs();
      tick();
      checks++;
      if (dct_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_accept got v=%0b want 0", dct_valid);
      end
   endtask

   task automatic test_flush();
      logic [1:0] seq [3] = '{2'b11, 2'b10, 2'b00};
      for (int i = 0; i < 3; i++) begin
         br_valid = 1; br_code = seq[i];
         tick();
      end
      br_valid = 0; flush_req = 1;
      tick();
      checks++;
      if (dct_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h38 || dut.acc_cnt !== 4'd0) begin
         errors++;
         $display("FAIL flush got v=%0b c=%0d b=%h acc_cnt=%0d want 1/3/38/0",
                  dct_valid, dct_count, dct_buffer, dut.acc_cnt);
      end
      flush_req = 0;
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      for (int i = 0; i < 31; i++) begin
         br_valid = 1; br_code = 2'b10;
         tick();
      end
      br_valid = 0;
      checks++;
      if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA ||
          dut.acc_cnt !== 4'd15 || dct_overflow !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold got v=%0b c=%0d b=%h acc_cnt=%0d o=%0b want 1/15/2aaaaaaa/15/1",
                  dct_valid, dct_count, dct_buffer, dut.acc_cnt, dct_overflow);
      end
      out_ready = 1;
      tick();
      checks++;
      if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA || dut.acc_cnt !== 4'd0) begin
         errors++;
         $display("FAIL bp_second got v=%0b c=%0d b=%h acc_cnt=%0d want 1/15/2aaaaaaa/0",
                  dct_valid, dct_count, dct_buffer, dut.acc_cnt);
      end
      tick();
      checks++;
      if (dct_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_done got v=%0b want 0", dct_valid);
      end
      overflow_clr = 1;
      tick();
      overflow_clr = 0;
   endtask

   task automatic test_drain();
      int c[$];
      out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         c.push_back(int'($urandom_range(0, 3)));
         br_valid = 1; br_code = 2'(c[i]);
         tick();
      end
      br_valid = 0; trc_on = 0;
      tick();
      checks++;
      if (dct_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_enter got v=%0b want 0", dct_valid);
      end
      tick();
      checks++;
      if (dct_valid !== 1'b1 || dct_count !== 4'd5 || dct_buffer !== pack_q(c)) begin
         errors++;
         $display("FAIL drain_frame got v=%0b c=%0d b=%h want 1/5/%h",
                  dct_valid, dct_count, dct_buffer, pack_q(c));
      end
      for (int i = 0; i < 4; i++) begin
         br_valid = 1; br_code = 2'($urandom_range(0, 3)); flush_req = (i == 2);
         tick();
         checks++;
         if (dct_valid !== 1'b0 || dct_overflow !== 1'b0) begin
            errors++;
            $display("FAIL off_ignore cyc %0d got v=%0b o=%0b want 0/0", i, dct_valid, dct_overflow);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      trc_on = 1; out_ready = 0;
      tick();
      for (int i = 0; i < 22; i++) begin
         br_valid = 1; br_code = 2'($urandom_range(0, 3));
         tick();
      end
      br_valid = 0;
      checks++;
      if (dct_valid !== 1'b1 || dut.acc_cnt !== 4'd7) begin
         errors++;
         $display("FAIL mid_setup got v=%0b acc_cnt=%0d want 1/7", dct_valid, dut.acc_cnt);
      end
      #2 reset_n = 0;
      m_reset();
      #1;
      checks++;
      if ({dct_valid, dct_count, dct_buffer, dct_overflow} !== 36'd0 || dut.acc_cnt !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset got v=%0b c=%0d b=%h o=%0b acc_cnt=%0d want all 0",
                  dct_valid, dct_count, dct_buffer, dct_overflow, dut.acc_cnt);
      end
      @(posedge clk);
      #3 reset_n = 1;
      out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (dct_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset cyc %0d got v=%0b want 0", i, dct_valid);
         end
      end
   endtask

   task automatic test_overflow_clr();
      out_ready = 0;
      for (int i = 0; i < 30; i++) begin
         br_valid = 1; br_code = 2'($urandom_range(0, 3));
         tick();
      end
      overflow_clr = 1;
      tick();
      checks++;
      if (dct_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_wins got o=%0b want 1", dct_overflow);
      end
      br_valid = 0;
      tick();
      checks++;
      if (dct_overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got o=%0b want 0", dct_overflow);
      end
      overflow_clr = 0; out_ready = 1;
      repeat (3) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         trc_on       = ($urandom_range(0, 99) < 92);
         br_valid     = ($urandom_range(0, 99) < 70);
         br_code      = 2'($urandom_range(0, 3));
         flush_req    = ($urandom_range(0, 99) < 8);
         out_ready    = ($urandom_range(0, 99) < 55);
         overflow_clr = ($urandom_range(0, 99) < 4);
         tick();
         checks++;
         if (dct_valid !== m_valid || dct_overflow !== m_ovf || dut.acc_cnt !== 4'(m_q.size()) ||
             (m_valid && (dct_count !== 4'(m_out.size()) || dct_buffer !== pack_q(m_out)))) begin
            errors++;
            $display("FAIL rnd cyc %0d got v=%0b c=%0d b=%h o=%0b n=%0d want v=%0b c=%0d b=%h o=%0b n=%0d",
                     i, dct_valid, dct_count, dct_buffer, dct_overflow, dut.acc_cnt,
                     m_valid, m_out.size(), pack_q(m_out), m_ovf, m_q.size());
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_flush();
      test_backpressure();
      test_drain();
      test_reset_mid();
      test_overflow_clr();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oci_dct_packer.md
OCI_DCT_PACKER -- requirements
Module: oci_dct_packer

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 15, codes per full frame, legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port trc_on  input  1  trace enable from OCI control.
REQ-005 SHALL have port br_valid  input  1  one 2-bit branch code offered this cycle.
REQ-006 SHALL have port br_code  input  2  branch code (bit order preserved).
REQ-007 SHALL have port flush_req  input  1  single-cycle request to emit the partial frame.
REQ-008 SHALL have port out_ready  input  1  downstream (OCI trace sink / test bench) accepts the frame.
REQ-009 SHALL have port overflow_clr  input  1  clears the sticky overflow flag.
REQ-010 SHALL have port dct_buffer  output  30  packed frame; newest code in [1:0], unused upper bits zero.
REQ-011 SHALL have port dct_count  output  4  number of valid codes in dct_buffer, 1..MAX_COUNT while valid.
REQ-012 SHALL have port dct_valid  output  1  frame held on dct_buffer/dct_count.
REQ-013 SHALL have port dct_overflow  output  1  sticky; at least one code was dropped.

Function
REQ-014 SHALL keep an accumulator acc[29:0] with counter acc_cnt[3:0] and an output register (dct_buffer, dct_count, dct_valid).
REQ-015 SHALL run FSM OFF / RUN / DRAIN: OFF->RUN when trc_on=1; RUN->DRAIN when trc_on=0 and acc_cnt>0; RUN->OFF when trc_on=0 and acc_cnt=0; DRAIN->OFF once the partial frame transfers to the output register.
REQ-016 SHALL accept a code only in RUN with trc_on=1 and br_valid=1; codes offered in OFF or DRAIN are ignored and do not set overflow.
REQ-017 SHALL append an accepted code as acc <= {acc[27:0], br_code}, acc_cnt <= acc_cnt+1.
REQ-018 SHALL treat the output register as free when dct_valid=0 or when dct_valid=1 and out_ready=1 in the same cycle.
REQ-019 SHALL, when an append makes acc_cnt reach MAX_COUNT and the output is free, load the completed frame (including that code) into the output register in the same edge, clear acc to 0 and acc_cnt to 0; frame latency: 1 cycle from the last code to dct_valid=1.
REQ-020 SHALL, when acc_cnt=MAX_COUNT and the output is not free, hold acc; any code accepted in that cycle is dropped and dct_overflow is set.
REQ-021 SHALL, when acc_cnt=MAX_COUNT and the output becomes free, transfer acc first; a code accepted in that same cycle starts the new acc with acc_cnt=1.
REQ-022 SHALL, on flush_req=1 with the output free, emit acc (with any code accepted that cycle appended, provided acc_cnt<MAX_COUNT) as a partial frame; when acc_cnt=0 and no code arrives, the flush is a no-op.
REQ-023 SHALL remember a flush that arrives while the output is busy and perform it at the first free cycle; pending flushes coalesce into one.
REQ-024 SHALL hold dct_buffer/dct_count/dct_valid stable while dct_valid=1 and out_ready=0, and clear dct_valid on accept unless a new frame loads in the same edge.
REQ-025 SHALL never present dct_valid=1 with dct_count=0.
REQ-026 SHALL, when overflow_clr and a drop occur in the same cycle, leave dct_overflow=1 (set wins).
REQ-027 SHALL zero-fill the bits of dct_buffer above 2*dct_count-1.

Reset
REQ-028 SHALL, while reset_n=0, immediately force FSM=OFF, acc=0, acc_cnt=0, pending flush=0, dct_buffer=0, dct_count=0, dct_valid=0, dct_overflow=0.
REQ-029 SHALL discard a partial frame and any held output frame on reset mid-operation; no frame is emitted after release until new codes arrive.
REQ-030 SHALL begin operation on the first rising clk edge after reset_n deasserts.

Verification
REQ-031 Bench SHALL cover: trc_on=1, out_ready=1, 15 codes 2'b01 on consecutive cycles -> next cycle dct_valid=1, dct_count=15, dct_buffer=30'h15555555.
REQ-032 Bench SHALL cover: codes 2'b11, 2'b10, 2'b00, then flush_req -> dct_count=3, dct_buffer=30'h38, acc_cnt=0 afterwards.
REQ-033 Bench SHALL cover: out_ready=0, 30 codes 2'b10, then a 31st code -> first frame held, acc full, dct_overflow=1; raising out_ready releases both frames in order, each dct_count=15, dct_buffer=30'h2AAAAAAA.
REQ-034 Bench SHALL cover: 5 codes then trc_on=0 -> DRAIN emits dct_count=5, FSM=OFF; codes offered while OFF produce no frame and no overflow.
REQ-035 Bench SHALL cover: reset_n pulsed low with acc_cnt=7 and dct_valid=1 -> all outputs 0 asynchronously, no frame after release.
REQ-036 Bench SHALL cover: overflow_clr and a drop in the same cycle -> dct_overflow stays 1; overflow_clr alone on the next cycle -> dct_overflow=0.
